// File: rtl/prog_seq.sv
// Programmable instruction sequencer: PC generation with conditional branches
// through a writable jump table, a bounded return stack for call/return, and
// an IDLE/RUN/HALT control FSM. All outputs are registered.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | after reset; waits for Start, all state holds
//   S_RUN  | sequencing; one PC decision per unstalled edge
//   S_HALT | program stopped; PC and Done hold until Start restarts
module prog_seq #(
    parameter int PC_W    = 6,
    parameter int JPTR_W  = 3,
    parameter int STACK_D = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Stall,
    input  logic              Br,
    input  logic [1:0]        Cond,
    input  logic              Zero,
    input  logic              Par,
    input  logic [JPTR_W-1:0] Jptr,
    input  logic              Call,
    input  logic              Ret,
    input  logic              Halt,
    input  logic              LutWen,
    input  logic [JPTR_W-1:0] LutWaddr,
    input  logic [PC_W-1:0]   LutWdat,
    output logic [PC_W-1:0]   PC,
    output logic              Done,
    output logic              Busy,
    output logic              StackErr
);

    localparam int LUT_N = 1 << JPTR_W;
    localparam int CNT_W = $clog2(STACK_D + 1);
    localparam int IDX_W = (STACK_D > 1) ? $clog2(STACK_D) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t            state;
    logic [PC_W-1:0]   lut   [LUT_N];
    logic [PC_W-1:0]   stack [STACK_D];
    logic [CNT_W-1:0]  sp;
    logic [CNT_W-1:0]  sp_m1;
    logic [IDX_W-1:0]  push_idx;
    logic [IDX_W-1:0]  pop_idx;
    logic [PC_W-1:0]   pc_inc;
    logic [PC_W-1:0]   lut_rd;
    logic              stk_full;
    logic              stk_empty;
    logic              cond_ok;
    logic              br_taken;

    assign sp_m1     = sp - 1'b1;
    assign push_idx  = sp[IDX_W-1:0];
    assign pop_idx   = sp_m1[IDX_W-1:0];
    assign stk_full  = (sp == CNT_W'(STACK_D));
    assign stk_empty = (sp == '0);
    assign pc_inc    = PC + 1'b1;
    assign lut_rd    = lut[Jptr];
    assign br_taken  = Br & cond_ok;

    // Branch condition decode from the ALU flags
    always_comb begin
        cond_ok = 1'b0;
        case (Cond)
            2'b00:   cond_ok = 1'b1;
            2'b01:   cond_ok = Zero;
            2'b10:   cond_ok = ~Zero;
            default: cond_ok = Par;
        endcase
    end

    // Jump table; the write lands at the edge so a same-cycle read sees the old entry
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < LUT_N; i++) lut[i] <= '0;
        end else if (LutWen) begin
            lut[LutWaddr] <= LutWdat;
        end
    end

    // Control FSM, PC, return stack and status flags
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= S_IDLE;
            PC       <= '0;
            Done     <= 1'b0;
            Busy     <= 1'b0;
            StackErr <= 1'b0;
            sp       <= '0;
            for (int i = 0; i < STACK_D; i++) stack[i] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        state    <= S_RUN;
                        PC       <= '0;
                        sp       <= '0;
                        StackErr <= 1'b0;
                        Busy     <= 1'b1;
                        Done     <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (!Stall) begin
                        if (Halt) begin
                            state <= S_HALT;
                            Busy  <= 1'b0;
                            Done  <= 1'b1;
                        end else if (Ret) begin
                            if (!stk_empty) begin
                                PC <= stack[pop_idx];
                                sp <= sp_m1;
                            end else begin
                                StackErr <= 1'b1;
                                PC       <= pc_inc;
                            end
                        end else if (Call) begin
                            if (!stk_full) begin
                                stack[push_idx] <= pc_inc;
                                sp              <= sp + 1'b1;
                                PC              <= lut_rd;
                            end else begin
                                StackErr <= 1'b1;
                                PC       <= pc_inc;
                            end
                        end else if (br_taken) begin
                            PC <= lut_rd;
                        end else begin
                            PC <= pc_inc;
                        end
                    end
                end
                S_HALT: begin
                    if (Start) begin
                        state    <= S_RUN;
                        PC       <= '0;
                        sp       <= '0;
                        StackErr <= 1'b0;
                        Busy     <= 1'b1;
                        Done     <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    Busy  <= 1'b0;
                    Done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_seq.sv
// Bench for prog_seq: directed instruction stream with a scoreboard of
// expected PC/Busy/Done/StackErr per clock edge.
module tb_prog_seq;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Start, Stall, Br, Zero, Par, Call, Ret, Halt, LutWen;
    logic [1:0] Cond;
    logic [2:0] Jptr, LutWaddr;
    logic [5:0] LutWdat;
    logic [5:0] PC;
    logic       Done, Busy, StackErr;

    typedef struct {
        logic [5:0] pc;
        logic       busy;
        logic       done;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_step = 0;

    prog_seq #(.PC_W(6), .JPTR_W(3), .STACK_D(4)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall), .Br(Br),
        .Cond(Cond), .Zero(Zero), .Par(Par), .Jptr(Jptr), .Call(Call),
        .Ret(Ret), .Halt(Halt), .LutWen(LutWen), .LutWaddr(LutWaddr),
        .LutWdat(LutWdat), .PC(PC), .Done(Done), .Busy(Busy),
        .StackErr(StackErr)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic clr_in();
        Start = 0; Stall = 0; Br = 0; Cond = 2'b00; Zero = 0; Par = 0;
        Jptr = 3'd0; Call = 0; Ret = 0; Halt = 0;
        LutWen = 0; LutWaddr = 3'd0; LutWdat = 6'd0;
    endtask

    task automatic pop_check();
        exp_t e;
        e = exp_q.pop_front();
        chk($sformatf("s%0d_pc", n_step),   32'(PC),       32'(e.pc));
        chk($sformatf("s%0d_busy", n_step), 32'(Busy),     32'(e.busy));
        chk($sformatf("s%0d_done", n_step), 32'(Done),     32'(e.done));
        chk($sformatf("s%0d_err", n_step),  32'(StackErr), 32'(e.err));
        n_step++;
    endtask

    // Inputs already driven; record expectation, take one edge, compare.
    task automatic step(input logic [5:0] pc, input logic b, input logic d, input logic er);
        exp_q.push_back('{pc: pc, busy: b, done: d, err: er});
        @(posedge Clk);
        #1;
        pop_check();
        clr_in();
    endtask

    task automatic lut_wr(input logic [2:0] a, input logic [5:0] v);
        LutWen = 1; LutWaddr = a; LutWdat = v;
    endtask

    task automatic do_br(input logic [1:0] c, input logic z, input logic p, input logic [2:0] j);
        Br = 1; Cond = c; Zero = z; Par = p; Jptr = j;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clr_in();
        Reset = 1;
        Start = 1;                       // must be ignored under reset
        #2;
        step(6'h00, 0, 0, 0);
        Reset = 0;

        // Jump table loaded while idle; state must hold
        lut_wr(3'd0, 6'h15); step(6'h00, 0, 0, 0);
        lut_wr(3'd1, 6'h10); step(6'h00, 0, 0, 0);
        lut_wr(3'd2, 6'h20); step(6'h00, 0, 0, 0);
        lut_wr(3'd3, 6'h3F); step(6'h00, 0, 0, 0);
        lut_wr(3'd4, 6'h09); step(6'h00, 0, 0, 0);
        lut_wr(3'd5, 6'h07); step(6'h00, 0, 0, 0);
        lut_wr(3'd6, 6'h03); step(6'h00, 0, 0, 0);

        Start = 1; step(6'h00, 1, 0, 0);
        for (int i = 1; i <= 7; i++) step(6'(i), 1, 0, 0);

        // Conditional branches
        do_br(2'b01, 0, 0, 3'd2); step(6'h08, 1, 0, 0);
        do_br(2'b00, 0, 0, 3'd5); step(6'h07, 1, 0, 0);
        do_br(2'b01, 1, 0, 3'd2); step(6'h20, 1, 0, 0);
        do_br(2'b11, 0, 0, 3'd6); step(6'h21, 1, 0, 0);
        do_br(2'b10, 0, 0, 3'd6); step(6'h03, 1, 0, 0);

        // Call / return
        Call = 1; Jptr = 3'd1; step(6'h10, 1, 0, 0);
        Ret = 1;               step(6'h04, 1, 0, 0);

        // Nested calls up to full, then overflow
        Call = 1; Jptr = 3'd1; step(6'h10, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            Call = 1; Jptr = 3'd1; step(6'h10, 1, 0, 0);
        end
        Call = 1; Jptr = 3'd1; step(6'h11, 1, 0, 1);
        for (int i = 0; i < 3; i++) begin
            Ret = 1; step(6'h11, 1, 0, 1);
        end
        Ret = 1; step(6'h05, 1, 0, 1);
        Ret = 1; step(6'h06, 1, 0, 1);   // underflow keeps PC+1 path

        // Wrap and stall, with a jump-table write during the stall
        do_br(2'b00, 0, 0, 3'd3); step(6'h3F, 1, 0, 1);
        for (int i = 0; i < 3; i++) begin
            Stall = 1; Halt = 1; Call = 1; do_br(2'b00, 0, 0, 3'd4);
            if (i == 0) lut_wr(3'd7, 6'h2A);
            step(6'h3F, 1, 0, 1);
        end
        step(6'h00, 1, 0, 1);
        do_br(2'b00, 0, 0, 3'd7); step(6'h2A, 1, 0, 1);
        do_br(2'b00, 0, 0, 3'd7); lut_wr(3'd7, 6'h11); step(6'h2A, 1, 0, 1);
        do_br(2'b00, 0, 0, 3'd7); step(6'h11, 1, 0, 1);

        // Halt beats Call; restart clears flags; no push happened
        do_br(2'b00, 0, 0, 3'd4); step(6'h09, 1, 0, 1);
        Halt = 1; Call = 1; Jptr = 3'd1; step(6'h09, 0, 1, 1);
        step(6'h09, 0, 1, 1);
        Start = 1; step(6'h00, 1, 0, 0);
        Ret = 1;   step(6'h01, 1, 0, 1);

        // Asynchronous reset mid-cycle
        do_br(2'b00, 0, 0, 3'd0); step(6'h15, 1, 0, 1);
        #3;
        Reset = 1;
        #1;
        exp_q.push_back('{pc: 6'h00, busy: 1'b0, done: 1'b0, err: 1'b0});
        pop_check();
        #1;
        Reset = 0;
        step(6'h00, 0, 0, 0);
        Start = 1; step(6'h00, 1, 0, 0);
        do_br(2'b00, 0, 0, 3'd2); step(6'h00, 1, 0, 0);
        do_br(2'b00, 0, 0, 3'd3); step(6'h00, 1, 0, 0);
        step(6'h01, 1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/prog_seq.md
PROG_SEQ -- requirements
Module: prog_seq

Interface
REQ-001 Parameter PC_W, default 6, program-counter width in bits.
REQ-002 Parameter JPTR_W, default 3, jump-table index width; the table holds 2^JPTR_W entries.
REQ-003 Parameter STACK_D, default 4, return-stack depth in entries (at least 1).
REQ-004 Port list; clock and reset are: Clk input 1 (single clock, all state on rising edge); Reset input 1 (asynchronous, active-high).
REQ-005 Start input 1: begin or restart execution at PC 0.
REQ-006 Stall input 1: freeze sequencing for this cycle.
REQ-007 Br input 1: conditional branch request.
REQ-008 Cond input 2: branch condition. 00 = always, 01 = Zero, 10 = !Zero, 11 = Par.
REQ-009 Zero input 1 and Par input 1: ALU flags, sampled in the same cycle as Br.
REQ-010 Jptr input JPTR_W: jump-table index for Br and Call.
REQ-011 Call input 1: subroutine call. Ret input 1: subroutine return. Halt input 1: stop execution.
REQ-012 LutWen input 1, LutWaddr input JPTR_W, LutWdat input PC_W: jump-table write port.
REQ-013 PC output PC_W: current instruction address.
REQ-014 Done output 1: program halted.
REQ-015 Busy output 1: high in the RUN state.
REQ-016 StackErr output 1: sticky flag for stack overflow or underflow.

Function
REQ-017 FSM states are IDLE, RUN and HALT; Busy = (state == RUN); Done = (state == HALT).
REQ-018 In IDLE with Start=1, the next state is RUN, PC is 0, the stack is emptied and StackErr is cleared; otherwise all state holds.
REQ-019 In HALT with Start=1, the same actions as REQ-018 apply and Done falls on the next edge; otherwise PC and Done hold.
REQ-020 In RUN with Stall=1, PC, state and stack hold; control inputs are ignored.
REQ-021 In RUN with Stall=0, exactly one action occurs per edge, in priority order: Halt > Ret > Call > taken Br > PC+1.
REQ-022 Halt: the next state is HALT, PC holds, and Done rises one cycle after the Halt is sampled.
REQ-023 Ret with a non-empty stack: PC is the popped entry. Ret with an empty stack: StackErr is set and PC becomes PC+1.
REQ-024 Call with a non-full stack: push PC+1 (mod 2^PC_W), then PC becomes LUT[Jptr]. Call with a full stack: StackErr is set, nothing is pushed, and PC becomes PC+1.
REQ-025 A branch is taken when Br=1 and Cond is satisfied; PC becomes LUT[Jptr]. An untaken branch gives PC+1.
REQ-026 PC increment wraps modulo 2^PC_W; all-ones + 1 = 0 with no error.
REQ-027 Latency: each sequencing decision is visible on PC one edge after the inputs are sampled; there is no combinational path from inputs to PC.
REQ-028 The LUT write is honoured in every state, including under Stall; it takes effect at the edge.
REQ-029 A same-cycle LUT write and read of the same index returns the old entry.
REQ-030 StackErr stays set until Reset or Start.
REQ-031 Stack depth is tracked with a counter from 0 to STACK_D; full = STACK_D and empty = 0.

Reset
REQ-032 Reset=1 immediately, without a clock, forces: state IDLE, PC=0, Done=0, Busy=0, StackErr=0, stack count 0, and all LUT entries 0.
REQ-033 Reset asserted mid-RUN or mid-Stall aborts the operation; after release the block waits in IDLE for Start.
REQ-034 No input has any effect while Reset=1.

Verification
REQ-035 Sequence: Reset, Start, then 5 idle cycles -> PC goes 0,1,2,3,4,5; Busy=1; Done=0.
REQ-036 Sequence: LUT[2]=0x20 written, then Br=1, Cond=01, Jptr=2, Zero=1 at PC 7 -> next PC is 0x20. The same stimulus with Zero=0 gives next PC 8.
REQ-037 Nesting and stack error: with LUT[1]=0x10, issue a Call at PC 3, then a Ret -> PC goes 0x10, then 4. With STACK_D=4, five nested Calls set StackErr on the fifth, and PC takes the PC+1 path.
REQ-038 Wrap and stall: at PC 63 (PC_W=6) with Stall=1 for 3 cycles -> PC holds 63, then goes to 0 after Stall falls.
REQ-039 Priority: Halt and Call together at PC 9 -> Done=1, PC=9, no push. Start then gives PC 0 and Done=0.
REQ-040 Async reset: Reset pulsed mid-cycle during RUN at PC 0x15 -> PC=0 and Busy=0 before the next edge; LUT entries read back as 0.
